tsp_text_stager: RTL and testbench

- Parametrised, double-buffered text loader feeding the PE array of the text search processor.
- Each HBM channel shifts beats into its own shadow bank, independent of the other channels.
- Once every channel is full, a swap request commits all shadow banks atomically into the active text bus that drives the PEs. The PEs never see a partially loaded text.
- Adds per-channel fill tracking, backpressure, overflow detection, text clear and an engine-busy interlock to the earlier fixed 32x64x128 shift loader.

---
 rtl/tsp_text_pkg.sv | 21 ++
 rtl/tsp_text_lane.sv | 78 +++++++
 rtl/tsp_text_stager.sv | 110 +++++++++++
 tb/tb_tsp_text_stager.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsp_text_pkg.sv
// ============================================================================
// tsp_text_pkg : shared types and width helpers for the text stager
// Rev 1.0
// ============================================================================
`default_nettype none

package tsp_text_pkg;

    // Fill counter must represent 0..BEATS inclusive.
    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } swap_state_e;

endpackage

`default_nettype wire

// File: rtl/tsp_text_lane.sv
// ============================================================================
// tsp_text_lane : per-channel shadow shift bank, fill counter and overflow flag
// Rev 1.0
// ============================================================================
`default_nettype none

module tsp_text_lane
    import tsp_text_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 128,
    parameter int CNT_W  = cnt_width(BEATS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_text,
    input  logic                    we_i,
    input  logic [BEAT_W-1:0]       wdata_i,
    input  logic                    commit_i,
    output logic [BEAT_W*BEATS-1:0] bank_o,
    output logic [CNT_W-1:0]        fill_o,
    output logic                    ready_o,
    output logic                    overflow_o
);

    localparam int              BANK_W = BEAT_W * BEATS;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(BEATS);

    logic [BANK_W-1:0] bank_q, bank_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic              w_full;

    assign w_full = (fill_q == FULL);

    always_comb begin
        bank_d = bank_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
        if (we_i) begin
            if (!w_full) begin
                bank_d = {wdata_i, bank_q[BANK_W-1:BEAT_W]};
                fill_d = fill_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        // A commit only happens with the lane full, so no write can race it.
        if (commit_i) begin
            fill_d = '0;
        end
        if (reset_text) begin
            bank_d = '0;
            fill_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bank_o     = bank_q;
    assign fill_o     = fill_q;
    assign ready_o    = !w_full;
    assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/tsp_text_stager.sv
// ============================================================================
// tsp_text_stager : double-buffered text loader with atomic swap into the PEs
// Rev 1.0
// ============================================================================
`default_nettype none

module tsp_text_stager
    import tsp_text_pkg::*;
#(
    parameter int N_CH   = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 128,
    parameter int CNT_W  = cnt_width(BEATS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_text,
    input  logic [N_CH*BEAT_W-1:0]       text_wdata,
    input  logic [N_CH-1:0]              text_we,
    output logic [N_CH-1:0]              text_ready,
    output logic [N_CH*CNT_W-1:0]        fill_level,
    output logic [N_CH-1:0]              overflow,
    input  logic                         swap_req,
    input  logic                         engine_busy,
    output logic                         swap_pending,
    output logic                         swap_done,
    output logic [N_CH*BEAT_W*BEATS-1:0] active_text,
    output logic                         active_valid
);

    localparam int BANK_W = BEAT_W * BEATS;

    swap_state_e               state_q, state_d;
    logic [N_CH*BANK_W-1:0]    w_shadow;
    logic [N_CH-1:0]           w_ready;
    logic                      w_all_full;
    logic                      w_commit;
    logic [N_CH*BANK_W-1:0]    active_q;
    logic                      valid_q;
    logic                      done_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        tsp_text_lane #(
            .BEAT_W (BEAT_W),
            .BEATS  (BEATS),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .reset_text (reset_text),
            .we_i       (text_we[c]),
            .wdata_i    (text_wdata[c*BEAT_W +: BEAT_W]),
            .commit_i   (w_commit),
            .bank_o     (w_shadow[c*BANK_W +: BANK_W]),
            .fill_o     (fill_level[c*CNT_W +: CNT_W]),
            .ready_o    (w_ready[c]),
            .overflow_o (overflow[c])
        );
    end

    assign text_ready = w_ready;
    assign w_all_full = ~|w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests arriving while already pending are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (swap_req) state_d = PEND;
            PEND:    if (w_all_full && !engine_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset_text) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        swap_pending = (state_q == PEND);
        w_commit     = (state_q == PEND) && w_all_full && !engine_busy && !reset_text;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= w_commit;
            if (w_commit) begin
                active_q <= w_shadow;
                valid_q  <= 1'b1;
            end
        end
    end

    assign active_text  = active_q;
    assign active_valid = valid_q;
    assign swap_done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tsp_text_stager.sv
// ============================================================================
// tb_tsp_text_stager : directed and randomized checks of the text stager
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tsp_text_stager;

    localparam int NC = 2;
    localparam int BW = 8;
    localparam int NB = 4;
    localparam int CW = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  reset_text = 1'b0;
    logic [NC*BW-1:0]      text_wdata = '0;
    logic [NC-1:0]         text_we = '0;
    logic [NC-1:0]         text_ready;
    logic [NC*CW-1:0]      fill_level;
    logic [NC-1:0]         overflow;
    logic                  swap_req = 1'b0;
    logic                  engine_busy = 1'b0;
    logic                  swap_pending;
    logic                  swap_done;
    logic [NC*BW*NB-1:0]   active_text;
    logic                  active_valid;

    int vectors = 0;
    int errors  = 0;

    tsp_text_stager #(.N_CH(NC), .BEAT_W(BW), .BEATS(NB)) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_text   (reset_text),
        .text_wdata   (text_wdata),
        .text_we      (text_we),
        .text_ready   (text_ready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .swap_req     (swap_req),
        .engine_busy  (engine_busy),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .active_text  (active_text),
        .active_valid (active_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; reset_text = 1'b0; text_we = '0; swap_req = 1'b0; engine_busy = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] we, input logic [7:0] d0, input logic [7:0] d1);
        text_we = we; text_wdata = {d1, d0};
        step();
        text_we = '0;
    endtask

    task automatic fill_both(input logic [31:0] c0, input logic [31:0] c1);
        for (int k = 0; k < NB; k++) wr2(2'b11, c0[k*8 +: 8], c1[k*8 +: 8]);
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (fill_level !== 6'd0) begin errors++; $display("FAIL reset_fill got=%h want=0", fill_level); end
        vectors++; if (text_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b want=11", text_ready); end
        vectors++; if ({overflow, swap_pending, swap_done, active_valid} !== 5'd0) begin errors++;
            $display("FAIL reset_flags got=%b want=00000", {overflow, swap_pending, swap_done, active_valid}); end
        vectors++; if (active_text !== 64'd0) begin errors++; $display("FAIL reset_active got=%h want=0", active_text); end
    endtask

    task automatic test_fill_commit();
        do_reset();
        fill_both(32'h44332211, 32'hA4A3A2A1);
        pulse_swap();
        vectors++; if ({swap_pending, active_valid, swap_done} !== 3'b100) begin errors++;
            $display("FAIL fc_pending got=%b want=100", {swap_pending, active_valid, swap_done}); end
        step();
        vectors++; if (active_text !== 64'hA4A3A2A1_44332211) begin errors++;
            $display("FAIL fc_active got=%h want=a4a3a2a144332211", active_text); end
        vectors++; if ({swap_pending, active_valid, swap_done} !== 3'b011) begin errors++;
            $display("FAIL fc_flags got=%b want=011", {swap_pending, active_valid, swap_done}); end
        vectors++; if (fill_level !== 6'd0 || text_ready !== 2'b11) begin errors++;
            $display("FAIL fc_fill got=%h/%b want=0/11", fill_level, text_ready); end
        step();
        vectors++; if (swap_done !== 1'b0) begin errors++; $display("FAIL fc_done_pulse got=%b want=0", swap_done); end
    endtask

    task automatic test_partial();
        do_reset();
        wr2(2'b11, 8'h11, 8'hA1);
        wr2(2'b11, 8'h22, 8'hA2);
        wr2(2'b01, 8'h33, 8'h00);
        wr2(2'b01, 8'h44, 8'h00);
        pulse_swap();
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({swap_pending, active_valid, swap_done} !== 3'b100) begin errors++;
                $display("FAIL partial_hold cyc=%0d got=%b want=100", i, {swap_pending, active_valid, swap_done}); end
            step();
        end
        vectors++; if (fill_level !== {3'd2, 3'd4}) begin errors++; $display("FAIL partial_fill got=%h want=14", fill_level); end
        wr2(2'b10, 8'h00, 8'hA3);
        wr2(2'b10, 8'h00, 8'hA4);
        vectors++; if ({swap_pending, swap_done} !== 2'b10) begin errors++;
            $display("FAIL partial_precommit got=%b want=10", {swap_pending, swap_done}); end
        step();
        vectors++; if (active_text !== 64'hA4A3A2A1_44332211 || swap_done !== 1'b1) begin errors++;
            $display("FAIL partial_commit got=%h done=%b want=a4a3a2a144332211 done=1", active_text, swap_done); end
    endtask

    task automatic test_busy();
        do_reset();
        fill_both(32'h04030201, 32'h08070605);
        engine_busy = 1'b1;
        pulse_swap();
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++; if ({swap_pending, active_valid, swap_done} !== 3'b100) begin errors++;
                $display("FAIL busy_hold cyc=%0d got=%b want=100", i, {swap_pending, active_valid, swap_done}); end
        end
        engine_busy = 1'b0;
        step();
        vectors++; if (active_text !== 64'h08070605_04030201 || swap_done !== 1'b1) begin errors++;
            $display("FAIL busy_release got=%h done=%b want=0807060504030201 done=1", active_text, swap_done); end
        step();
        vectors++; if (swap_done !== 1'b0) begin errors++; $display("FAIL busy_done_pulse got=%b want=0", swap_done); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill_both(32'h44332211, 32'hA4A3A2A1);
        wr2(2'b01, 8'hFF, 8'h00);
        vectors++; if (overflow !== 2'b01 || text_ready[0] !== 1'b0 || fill_level[2:0] !== 3'd4) begin errors++;
            $display("FAIL ovf_flag got=%b/%b/%0d want=01/0/4", overflow, text_ready[0], fill_level[2:0]); end
        pulse_swap();
        // Write into full ch1 during the commit cycle: dropped, flags overflow.
        text_we = 2'b10; text_wdata = 16'hEE00;
        step();
        text_we = '0;
        vectors++; if (active_text !== 64'hA4A3A2A1_44332211) begin errors++;
            $display("FAIL ovf_commit got=%h want=a4a3a2a144332211", active_text); end
        vectors++; if (overflow !== 2'b11 || fill_level !== 6'd0) begin errors++;
            $display("FAIL ovf_sticky got=%b/%h want=11/0", overflow, fill_level); end
    endtask

    task automatic test_clear();
        do_reset();
        fill_both(32'h44332211, 32'hA4A3A2A1);
        pulse_swap();
        step();
        fill_both(32'h5A5B5C5D, 32'h6A6B6C6D);
        wr2(2'b01, 8'h77, 8'h00);
        pulse_swap();
        reset_text = 1'b1;
        step();
        reset_text = 1'b0;
        vectors++; if (active_text !== 64'hA4A3A2A1_44332211 || active_valid !== 1'b1) begin errors++;
            $display("FAIL clr_active got=%h v=%b want=a4a3a2a144332211 v=1", active_text, active_valid); end
        vectors++; if ({swap_pending, swap_done, overflow} !== 4'd0 || fill_level !== 6'd0) begin errors++;
            $display("FAIL clr_state got=%b fill=%h want=0000 fill=0", {swap_pending, swap_done, overflow}, fill_level); end
        step();
        vectors++; if (swap_done !== 1'b0 || active_text !== 64'hA4A3A2A1_44332211) begin errors++;
            $display("FAIL clr_nodone got=%b/%h want=0/a4a3a2a144332211", swap_done, active_text); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr2(2'b11, 8'h55, 8'hB5);
        wr2(2'b11, 8'h66, 8'hB6);
        do_reset();
        vectors++; if (fill_level !== 6'd0 || text_ready !== 2'b11 || active_text !== 64'd0 || active_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_clear got=%h/%b/%h/%b want=0/11/0/0", fill_level, text_ready, active_text, active_valid); end
        fill_both(32'h04030201, 32'h0C0B0A09);
        pulse_swap();
        step();
        vectors++; if (active_text !== 64'h0C0B0A09_04030201) begin errors++;
            $display("FAIL rmid_commit got=%h want=0c0b0a0904030201", active_text); end
    endtask

    // Reference model: each channel holds an ordered list of the last NB beats.
    task automatic test_random();
        logic [7:0] m_sh [NC][NB];
        logic [7:0] m_act[NC][NB];
        int         m_fill[NC];
        logic [NC-1:0] m_ovf;
        logic m_pend, m_done, m_valid, all_full, commit;
        logic [NC*BW*NB-1:0] e_act;
        logic [NC*CW-1:0]    e_fill;
        logic [NC-1:0]       e_rdy;
        do_reset();
        for (int c = 0; c < NC; c++) begin
            m_fill[c] = 0;
            for (int k = 0; k < NB; k++) begin m_sh[c][k] = 8'd0; m_act[c][k] = 8'd0; end
        end
        m_ovf = '0; m_pend = 0; m_done = 0; m_valid = 0;
        for (int it = 0; it < 400; it++) begin
            for (int c = 0; c < NC; c++) text_we[c] = ($urandom_range(0, 3) != 0);
            text_wdata  = 16'($urandom);
            swap_req    = ($urandom_range(0, 5) == 0);
            engine_busy = ($urandom_range(0, 3) == 0);
            reset_text  = ($urandom_range(0, 59) == 0);
            all_full = 1'b1;
            for (int c = 0; c < NC; c++) if (m_fill[c] != NB) all_full = 1'b0;
            commit = m_pend && all_full && !engine_busy && !reset_text;
            if (reset_text) begin
                for (int c = 0; c < NC; c++) begin
                    m_fill[c] = 0;
                    for (int k = 0; k < NB; k++) m_sh[c][k] = 8'd0;
                end
                m_ovf = '0; m_pend = 0;
            end else begin
                if (commit) begin
                    for (int c = 0; c < NC; c++) for (int k = 0; k < NB; k++) m_act[c][k] = m_sh[c][k];
                    m_valid = 1; m_pend = 0;
                end else if (!m_pend && swap_req) begin
                    m_pend = 1;
                end
                for (int c = 0; c < NC; c++) begin
                    if (text_we[c]) begin
                        if (m_fill[c] < NB) begin
                            for (int k = 0; k < NB - 1; k++) m_sh[c][k] = m_sh[c][k+1];
                            m_sh[c][NB-1] = text_wdata[c*BW +: BW];
                            m_fill[c]++;
                        end else begin
                            m_ovf[c] = 1'b1;
                        end
                    end
                    if (commit) m_fill[c] = 0;
                end
            end
            m_done = commit;
            step();
            for (int c = 0; c < NC; c++) begin
                e_fill[c*CW +: CW] = CW'(m_fill[c]);
                e_rdy[c] = (m_fill[c] != NB);
                for (int k = 0; k < NB; k++) e_act[(c*NB + k)*BW +: BW] = m_act[c][k];
            end
            vectors++; if (active_text !== e_act) begin errors++; $display("FAIL rnd_active it=%0d got=%h want=%h", it, active_text, e_act); end
            vectors++; if (fill_level !== e_fill || text_ready !== e_rdy) begin errors++;
                $display("FAIL rnd_fill it=%0d got=%h/%b want=%h/%b", it, fill_level, text_ready, e_fill, e_rdy); end
            vectors++; if ({overflow, swap_pending, swap_done, active_valid} !== {m_ovf, m_pend, m_done, m_valid}) begin errors++;
                $display("FAIL rnd_flags it=%0d got=%b want=%b", it, {overflow, swap_pending, swap_done, active_valid},
                         {m_ovf, m_pend, m_done, m_valid}); end
        end
        text_we = '0; swap_req = 1'b0; engine_busy = 1'b0; reset_text = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_commit();
        test_partial();
        test_busy();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
